os_xor2_mac_seq: RTL and testbench
==================================

# os_xor2_mac_seq

Sequencer that streams operand beats through the combinational `OS_XOR2_17` GF(2) partial-product core and XOR-accumulates the 7-bit core outputs over a burst. It sits between an upstream operand source and the core instance. It registers each accepted beat onto the core inputs, folds `core_y` into an accumulator, and presents one accumulated result per burst on a valid/ready output.

## Interface
- `MAX_LEN`, default 16: maximum beats per burst.
- `LEN_W`, default 5: width of `len`; must hold `MAX_LEN`.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `len`  in  LEN_W  beat count for the burst, sampled with `start`.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  operand beat accepted when high with `in_valid`.
- `in_a0`, `in_b0`, `in_a1`, `in_b1`  in  8 each  operand beat.
- `core_a0`, `core_b0`, `core_a1`, `core_b1`  out  8 each  registered drive to the core.
- `core_y`  in  7  combinational core output.
- `out_valid`  out  1  accumulated result available.
- `out_ready`  in  1  result consumer ready.
- `out_y`  out  7  accumulated result.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle pulse when a `start` is rejected.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, `start` with 1 ≤ `len` ≤ `MAX_LEN`:
  - load `remaining = len`;
  - clear the accumulator;
  - go to RUN.
- IDLE, `start` with `len` = 0 or `len` > `MAX_LEN`:
  - pulse `err` for one cycle;
  - stay in IDLE.
- RUN:
  - `in_ready = (remaining != 0)`.
  - Each handshake loads `in_*` into the core operand registers and decrements `remaining`.
  - Cycles with no handshake load zeros into the core operand registers. All-zero operands make the core output 7'h00.
  - When the last beat is accepted, go to DRAIN.
- Accumulate every cycle in RUN and DRAIN while a beat is in flight: `acc <= acc ^ core_y`. A beat is in flight if the core registers were loaded from a handshake on the previous edge.
- DRAIN: lasts one cycle, in which the final in-flight beat is accumulated. Then go to DONE with the core registers zeroed.
- DONE:
  - `out_valid` = 1 and `out_y` = acc;
  - both held stable until `out_ready`;
  - on the handshake, go to IDLE.
- `start` outside IDLE is ignored: no `err`, no state change. This includes the DONE handshake cycle.
- Arithmetic is a 7-bit XOR only, with no carries. The accumulator never saturates or overflows.
- `in_valid` low in RUN stalls the burst indefinitely. There is no timeout.

## Timing
- Reset values, applied asynchronously:
  - state = IDLE; `remaining` = 0; acc = 0;
  - `core_*` = 0; `in_ready` = 0; `out_valid` = 0; `out_y` = 0; `busy` = 0; `err` = 0.
- `start` in IDLE at edge t puts the block in RUN at t+1. `in_ready` can be high in the cycle after t.
- A beat accepted at edge t:
  - drives the core during cycle t→t+1;
  - is folded into acc at edge t+1.
- Last beat accepted at edge t: DRAIN during t→t+1, DONE from t+1. `out_valid` rises at t+1, so there are 2 edges from the last-beat handshake to the result.
- Back-to-back beats with no bubbles sustain 1 beat/cycle.
- Minimum burst of length 1: start → RUN → DRAIN → DONE, with `out_valid` 3 cycles after `start`.
- `out_valid` falls on the edge where `out_valid & out_ready`. The block is in IDLE the following cycle, and a new `start` is accepted from then on.
- `rst_n` asserted mid-burst:
  - all state clears immediately;
  - any partial acc is discarded;
  - `in_ready` and `out_valid` drop without waiting for a clock.
- Deassertion of `rst_n` is synchronized externally. The block itself has no synchronizer.

## Test plan
- len=1, one beat with a1=8'h01, b1=8'h01, a0=b0=0 → `core_y`=7'h01; `out_valid` 2 edges after the beat; `out_y`=7'h01.
- len=3, three identical beats as above, back to back → `out_y`=7'h01. Repeat with len=2 → `out_y`=7'h00.
- len=2, beats (a1=8'h01, b1=8'h01) then (a1=8'h02, b1=8'h01), with `in_valid` low 3 cycles between them:
  - `core_*` = 0 during the gap;
  - `out_y`=7'h03.
- `start` with len=0, then with len=17 (`MAX_LEN`=16) → `err` pulses once for each, `busy` stays 0. A `start` during RUN is ignored and the burst result is unchanged.
- DONE with `out_ready` held low 5 cycles → `out_valid` and `out_y` stable. `out_ready`=1 together with `start` → handshake completes, that `start` is ignored, and the next-cycle `start` is accepted.
- `rst_n` pulsed low after 2 of 4 beats → all outputs at reset values immediately. A new len=1 burst yields only its own beat's `core_y`.

Source files
------------

// File: rtl/os_xor2_mac_seq_if.sv
// Handshake/bus bundle for os_xor2_mac_seq.
//   start/len            : burst request and beat count
//   in_valid/in_ready    : operand beat handshake, in_a0/in_b0/in_a1/in_b1 operands
//   core_a0..core_b1     : registered drive to the GF(2) core
//   core_y               : combinational core result
//   out_valid/out_ready  : accumulated result handshake, out_y result
//   busy/err             : status (not idle) and rejected-start pulse
// slave is the sequencer's view, master is the surrounding system's view.
interface os_xor2_mac_seq_if #(
  parameter int LEN_W = 5
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a0, in_b0, in_a1, in_b1;
  logic [7:0]       core_a0, core_b0, core_a1, core_b1;
  logic [6:0]       core_y;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_y;
  logic             busy;
  logic             err;

  modport slave (
    input  start, len, in_valid, in_a0, in_b0, in_a1, in_b1, core_y, out_ready,
    output in_ready, core_a0, core_b0, core_a1, core_b1, out_valid, out_y, busy, err
  );

  modport master (
    output start, len, in_valid, in_a0, in_b0, in_a1, in_b1, core_y, out_ready,
    input  in_ready, core_a0, core_b0, core_a1, core_b1, out_valid, out_y, busy, err
  );
endinterface

// File: rtl/os_xor2_mac_seq.sv
// Burst sequencer around the combinational OS_XOR2_17 GF(2) core.
// Accepted operand beats are registered onto the core inputs; the 7-bit core
// output is XOR-folded into an accumulator one edge later. One accumulated
// result per burst is offered on out_valid/out_ready.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : os_xor2_mac_seq_if.slave (request, operand, core and result signals)
module os_xor2_mac_seq #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  os_xor2_mac_seq_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [6:0]       acc_q, acc_d;
  logic [7:0]       a0_q, b0_q, a1_q, b1_q;
  logic [7:0]       a0_d, b0_d, a1_d, b1_d;
  // Core registers hold a real beat (not zero fill) this cycle.
  logic             infl_q, infl_d;
  logic             err_q, err_d;

  logic             in_rdy;
  logic             hs;
  logic             len_ok;

  assign len_ok = (bus.len != '0) && (bus.len <= LEN_W'(MAX_LEN));
  assign in_rdy = (state_q == RUN) && (rem_q != '0);
  assign hs     = in_rdy && bus.in_valid;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    // Core operands fall back to zero whenever no beat is accepted, so the
    // core output is 0 in bubbles and outside a burst.
    a0_d    = '0;
    b0_d    = '0;
    a1_d    = '0;
    b1_d    = '0;
    infl_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            rem_d   = bus.len;
            acc_d   = '0;
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
          end
        end
      end

      RUN: begin
        if (infl_q) acc_d = acc_q ^ bus.core_y;
        if (hs) begin
          a0_d   = bus.in_a0;
          b0_d   = bus.in_b0;
          a1_d   = bus.in_a1;
          b1_d   = bus.in_b1;
          infl_d = 1'b1;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end

      // Folds the last beat, which was accepted on the edge entering DRAIN.
      DRAIN: begin
        if (infl_q) acc_d = acc_q ^ bus.core_y;
        state_d = DONE;
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      a0_q    <= '0;
      b0_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      infl_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      infl_q  <= infl_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.core_a0   = a0_q;
  assign bus.core_b0   = b0_q;
  assign bus.core_a1   = a1_q;
  assign bus.core_b1   = b1_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_y     = acc_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_os_xor2_mac_seq.sv
module tb_os_xor2_mac_seq;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  os_xor2_mac_seq_if #(.LEN_W(LEN_W)) bus ();

  os_xor2_mac_seq #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in core: carry-less products of both operand pairs, XORed, low 7 bits.
  function automatic logic [6:0] core_f(input logic [7:0] a0, input logic [7:0] b0,
                                        input logic [7:0] a1, input logic [7:0] b1);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b0[i]) p = p ^ (16'(a0) << i);
      if (b1[i]) p = p ^ (16'(a1) << i);
    end
    return p[6:0];
  endfunction

  assign bus.core_y = core_f(bus.core_a0, bus.core_b0, bus.core_a1, bus.core_b1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int l);
    bus.start = 1'b1;
    bus.len   = LEN_W'(l);
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  // One beat; waits (bounded) for in_ready, then handshakes on the next edge.
  task automatic beat(input logic [7:0] a0, input logic [7:0] b0,
                      input logic [7:0] a1, input logic [7:0] b1);
    int n;
    bus.in_valid = 1'b1;
    bus.in_a0 = a0; bus.in_b0 = b0; bus.in_a1 = a1; bus.in_b1 = b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("beat_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_a0 = '0; bus.in_b0 = '0; bus.in_a1 = '0; bus.in_b1 = '0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a0 = '0; bus.in_b0 = '0; bus.in_a1 = '0; bus.in_b1 = '0;
    #2;
    // Reset state
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_y",     32'(bus.out_y),     32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_core_a1",   32'(bus.core_a1),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // len=1: out_valid 2 edges after the beat, 3 after start
    req(1);
    chk("l1_busy",     32'(bus.busy),     32'd1);
    chk("l1_in_ready", 32'(bus.in_ready), 32'd1);
    beat(8'h00, 8'h00, 8'h01, 8'h01);
    chk("l1_core_a1",  32'(bus.core_a1),   32'h01);
    chk("l1_core_y",   32'(bus.core_y),    32'h01);
    chk("l1_drain_rdy",32'(bus.in_ready),  32'd0);
    chk("l1_ov_early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("l1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("l1_out_y",     32'(bus.out_y),     32'h01);
    consume();
    chk("l1_ov_fall",  32'(bus.out_valid), 32'd0);
    chk("l1_idle",     32'(bus.busy),      32'd0);

    // len=3 identical back-to-back beats -> 1
    req(3);
    for (int i = 0; i < 3; i++) beat(8'h00, 8'h00, 8'h01, 8'h01);
    tick();
    chk("l3_out_valid", 32'(bus.out_valid), 32'd1);
    chk("l3_out_y",     32'(bus.out_y),     32'h01);
    consume();

    // len=2 identical beats cancel -> 0
    req(2);
    for (int i = 0; i < 2; i++) beat(8'h00, 8'h00, 8'h01, 8'h01);
    tick();
    chk("l2_out_valid", 32'(bus.out_valid), 32'd1);
    chk("l2_out_y",     32'(bus.out_y),     32'h00);
    consume();

    // len=2 with a 3-cycle bubble: core zeroed in the gap, 1^2 = 3
    req(2);
    beat(8'h00, 8'h00, 8'h01, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_core_a1", 32'(bus.core_a1), 32'd0);
      chk("gap_core_b1", 32'(bus.core_b1), 32'd0);
      chk("gap_busy",    32'(bus.busy),    32'd1);
    end
    beat(8'h00, 8'h00, 8'h02, 8'h01);
    tick();
    chk("gap_out_valid", 32'(bus.out_valid), 32'd1);
    chk("gap_out_y",     32'(bus.out_y),     32'h03);
    consume();

    // Rejected starts
    req(0);
    chk("len0_err",  32'(bus.err),  32'd1);
    chk("len0_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("len0_err_pulse", 32'(bus.err), 32'd0);
    req(17);
    chk("len17_err",  32'(bus.err),  32'd1);
    chk("len17_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("len17_err_pulse", 32'(bus.err), 32'd0);

    // start during RUN ignored: clmul(3,3)=5, clmul(2,1)=2 -> 7
    req(2);
    bus.start = 1'b1;
    bus.len   = LEN_W'(5);
    beat(8'h03, 8'h03, 8'h00, 8'h00);
    chk("run_start_err", 32'(bus.err), 32'd0);
    beat(8'h00, 8'h00, 8'h02, 8'h01);
    bus.start = 1'b0;
    bus.len   = '0;
    tick();
    chk("run_start_ov", 32'(bus.out_valid), 32'd1);
    chk("run_start_y",  32'(bus.out_y),     32'h07);
    consume();

    // DONE held with out_ready low
    req(1);
    beat(8'h00, 8'h00, 8'h04, 8'h01);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_ov", 32'(bus.out_valid), 32'd1);
      chk("hold_y",  32'(bus.out_y),     32'h04);
      tick();
    end
    // Handshake together with start: start ignored
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.len       = LEN_W'(1);
    tick();
    bus.out_ready = 1'b0;
    chk("hs_ov_fall",  32'(bus.out_valid), 32'd0);
    chk("hs_start_ign",32'(bus.busy),      32'd0);
    chk("hs_no_err",   32'(bus.err),       32'd0);
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
    chk("next_start_acc", 32'(bus.busy), 32'd1);
    beat(8'h00, 8'h00, 8'h01, 8'h01);
    tick();
    chk("next_out_y", 32'(bus.out_y), 32'h01);
    consume();

    // Reset mid-burst after 2 of 4 beats
    req(4);
    beat(8'h00, 8'h00, 8'h01, 8'h01);
    beat(8'h00, 8'h00, 8'h02, 8'h01);
    bus.in_valid = 1'b1;
    bus.in_a1 = 8'h01; bus.in_b1 = 8'h01;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready),  32'd0);
    chk("mid_rst_busy",     32'(bus.busy),      32'd0);
    chk("mid_rst_core_a1",  32'(bus.core_a1),   32'd0);
    chk("mid_rst_out_y",    32'(bus.out_y),     32'd0);
    chk("mid_rst_ov",       32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    bus.in_a1 = '0; bus.in_b1 = '0;
    tick();
    rst_n = 1'b1;
    tick();
    req(1);
    beat(8'h00, 8'h00, 8'h08, 8'h01);
    tick();
    chk("post_rst_ov", 32'(bus.out_valid), 32'd1);
    chk("post_rst_y",  32'(bus.out_y),     32'h08);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
